nw_fill_ctrl: RTL

//  Sequencer for the Needleman-Wunsch matrix fill. It drives the score-matrix RAM directly.
//  - Init phase: writes gap penalties into row 0 and column 0.
//  - Fill phase: walks every cell (i,j) in order. For each cell it reads diag/up/left, fetches
//    the two residues, computes the cell score and writes the result back.
//  On completion it reports the final alignment score for the traceback stage downstream.

---
 rtl/nw_fill_ctrl_pkg.sv | 42 ++++
 rtl/nw_fill_ctrl_cell_max.sv | 60 ++++++
 rtl/nw_fill_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/nw_fill_ctrl_pkg.sv
// Shared definitions for the Needleman-Wunsch fill sequencer: score defaults,
// traceback direction codes, FSM state encoding and the 9-bit saturation helper.
// Pure declarations, no timing and no flow control of their own.
package nw_fill_ctrl_pkg;

  localparam int N_DEF = 128;

  localparam logic signed [8:0] MATCH_DEF    = 9'sd1;
  localparam logic signed [8:0] MISMATCH_DEF = -9'sd1;
  localparam logic signed [8:0] GAP_DEF      = -9'sd1;

  // Traceback direction codes reported with each written cell
  typedef enum logic [1:0] {
    DIR_DIAG = 2'b00,
    DIR_UP   = 2'b01,
    DIR_LEFT = 2'b10
  } dir_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Clamp a wide signed intermediate into the stored score range [-256,255]
  function automatic logic signed [8:0] sat9(input logic signed [17:0] v);
    logic signed [8:0] r;
    if (v > 18'sd255) begin
      r = 9'sd255;
    end else if (v < -18'sd256) begin
      r = -9'sd256;
    end else begin
      r = v[8:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/nw_fill_ctrl_cell_max.sv
// Cell scorer: best of diag+match/mismatch, up+gap, left+gap, saturated to 9 bits.
// Latency: purely combinational. No flow control; the sequencer samples it in CALC.
// With NW_TRACE_DIR_EN defined it also reports which candidate won.
module nw_fill_ctrl_cell_max
  import nw_fill_ctrl_pkg::*;
#(
  parameter logic signed [8:0] MATCH    = MATCH_DEF,
  parameter logic signed [8:0] MISMATCH = MISMATCH_DEF,
  parameter logic signed [8:0] GAP      = GAP_DEF
) (
  input  logic              match,
  input  logic signed [8:0] diag,
  input  logic signed [8:0] up,
  input  logic signed [8:0] left,
  output logic signed [8:0] score
`ifdef NW_TRACE_DIR_EN
  ,
  output logic [1:0]        dir
`endif
);

  // One bit of headroom so the sums never wrap before saturation
  logic signed [9:0] d_sum;
  logic signed [9:0] u_sum;
  logic signed [9:0] l_sum;
  logic signed [9:0] best;
  logic              pick_d;
  logic              pick_u;

  // Candidate sums and winner selection; ties resolve diag, then up, then left
  always_comb begin
    d_sum  = 10'(diag) + (match ? 10'(MATCH) : 10'(MISMATCH));
    u_sum  = 10'(up) + 10'(GAP);
    l_sum  = 10'(left) + 10'(GAP);
    pick_d = (d_sum >= u_sum) && (d_sum >= l_sum);
    pick_u = !pick_d && (u_sum >= l_sum);
    if (pick_d) begin
      best = d_sum;
    end else if (pick_u) begin
      best = u_sum;
    end else begin
      best = l_sum;
    end
    score = sat9(18'(best));
  end

`ifdef NW_TRACE_DIR_EN
  // Direction code of the winning candidate
  always_comb begin
    if (pick_d) begin
      dir = DIR_DIAG;
    end else if (pick_u) begin
      dir = DIR_UP;
    end else begin
      dir = DIR_LEFT;
    end
  end
`endif

endmodule

// File: rtl/nw_fill_ctrl.sv
// Needleman-Wunsch fill sequencer: writes the gap row/column, then read/calc/write per cell.
// Latency: (max(len_a,len_b)+1) + 3*len_a*len_b + 1 cycles from start to done.
// No backpressure: the RAM and residue memories are assumed ready every cycle; start while busy is dropped.
// Optional: define NW_TRACE_DIR_EN to add the dir/dir_we traceback outputs.
module nw_fill_ctrl
  import nw_fill_ctrl_pkg::*;
#(
  parameter int                N        = N_DEF,
  parameter int                BitAddr  = $clog2(N),
  parameter logic signed [8:0] MATCH    = MATCH_DEF,
  parameter logic signed [8:0] MISMATCH = MISMATCH_DEF,
  parameter logic signed [8:0] GAP      = GAP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BitAddr:0]     len_a,
  input  logic [BitAddr:0]     len_b,
  output logic [BitAddr:0]     seq_addr_a,
  output logic [BitAddr:0]     seq_addr_b,
  input  logic [1:0]           char_a,
  input  logic [1:0]           char_b,
  output logic                 en_init,
  output logic                 en_ins_read,
  output logic                 we,
  output logic [BitAddr:0]     addr,
  output logic signed [8:0]    data,
  output logic [BitAddr:0]     i,
  output logic [BitAddr:0]     j,
  output logic signed [8:0]    max,
  input  logic signed [8:0]    diag,
  input  logic signed [8:0]    up,
  input  logic signed [8:0]    left,
  output logic                 busy,
  output logic                 done,
  output logic signed [8:0]    final_score
`ifdef NW_TRACE_DIR_EN
  ,
  output logic [1:0]           dir,
  output logic                 dir_we
`endif
);

  localparam int               AW      = BitAddr + 1;
  localparam logic [BitAddr:0] LEN_MAX = AW'(N);
  localparam logic [BitAddr:0] ONE     = AW'(1);

  state_e state;
  state_e state_nxt;

  // Run lengths captured at start (already clamped) and the larger of the two
  logic [BitAddr:0] len_a_q;
  logic [BitAddr:0] len_b_q;
  logic [BitAddr:0] len_m_q;
  logic [BitAddr:0] len_a_c;
  logic [BitAddr:0] len_b_c;
  logic [BitAddr:0] len_m_c;

  logic              empty_run;
  logic              init_last;
  logic              row_end;
  logic              last_cell;
  logic signed [17:0] init_prod;
  logic signed [8:0]  init_val;
  logic signed [8:0]  cell_score;

  // Requested lengths beyond the matrix edge are clamped to it
  always_comb begin
    len_a_c = (len_a > LEN_MAX) ? LEN_MAX : len_a;
    len_b_c = (len_b > LEN_MAX) ? LEN_MAX : len_b;
    len_m_c = (len_a_c > len_b_c) ? len_a_c : len_b_c;
  end

  assign empty_run = (len_a_q == '0) || (len_b_q == '0);
  assign init_last = (addr == len_m_q);
  assign row_end   = (i == len_a_q);
  assign last_cell = row_end && (j == len_b_q);

  // Border value for index addr; also the final score of a run with an empty sequence
  assign init_prod = 18'(signed'({1'b0, addr})) * 18'(GAP);
  assign init_val  = sat9(init_prod);

`ifdef NW_TRACE_DIR_EN
  logic [1:0] cell_dir;
  logic [1:0] dir_q;
`endif

  nw_fill_ctrl_cell_max #(
    .MATCH    (MATCH),
    .MISMATCH (MISMATCH),
    .GAP      (GAP)
  ) u_cell_max (
    .match (char_a == char_b),
    .diag  (diag),
    .up    (up),
    .left  (left),
    .score (cell_score)
`ifdef NW_TRACE_DIR_EN
    ,
    .dir   (cell_dir)
`endif
  );

  // State register; reset aborts any run immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: init sweep, then three cycles per cell, then a one-cycle done
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_INIT;
      ST_INIT:  if (init_last) state_nxt = empty_run ? ST_DONE : ST_READ;
      ST_READ:  state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_cell ? ST_DONE : ST_READ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Run parameters, init index, cell walk (i inner, j outer) and score registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_a_q     <= '0;
      len_b_q     <= '0;
      len_m_q     <= '0;
      addr        <= '0;
      i           <= '0;
      j           <= '0;
      max         <= '0;
      final_score <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len_a_q     <= len_a_c;
            len_b_q     <= len_b_c;
            len_m_q     <= len_m_c;
            addr        <= '0;
            final_score <= '0;
          end
        end
        ST_INIT: begin
          if (init_last) begin
            if (empty_run) begin
              final_score <= init_val;
            end else begin
              i <= ONE;
              j <= ONE;
            end
          end else begin
            addr <= addr + ONE;
          end
        end
        ST_CALC: begin
          max <= cell_score;
        end
        ST_WRITE: begin
          // The last cell leaves i/j pointing at (len_a,len_b)
          if (last_cell) begin
            final_score <= max;
          end else if (row_end) begin
            i <= ONE;
            j <= j + ONE;
          end else begin
            i <= i + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM strobes, border data and residue addresses decoded from the current state
  always_comb begin
    en_init     = 1'b0;
    en_ins_read = 1'b0;
    we          = 1'b0;
    data        = '0;
    seq_addr_a  = '0;
    seq_addr_b  = '0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    unique case (state)
      ST_INIT: begin
        en_init = 1'b1;
        we      = 1'b1;
        data    = init_val;
      end
      ST_READ: begin
        en_ins_read = 1'b1;
        seq_addr_a  = i - ONE;
        seq_addr_b  = j - ONE;
      end
      ST_WRITE: begin
        en_ins_read = 1'b1;
        we          = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef NW_TRACE_DIR_EN
  // Winning direction is captured together with the cell score
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= '0;
    end else if (state == ST_CALC) begin
      dir_q <= cell_dir;
    end
  end

  // Direction strobe accompanies the cell write
  always_comb begin
    dir_we = (state == ST_WRITE);
    dir    = dir_we ? dir_q : 2'b00;
  end
`endif

endmodule
